// File: rtl/sd_ramdisk_pkg.sv
// Shared types and constants for the SDRAM-backed SD sector responder.
package sd_ramdisk_pkg;

    // Transfer sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_REQ    = 3'd1,
        ST_RD_STROBE = 3'd2,
        ST_WR_ADDR   = 3'd3,
        ST_WR_REQ    = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    // One SD sector.
    localparam int SECTOR_BYTES = 512;

    // Index of the final byte in a sector.
    localparam logic [8:0] LAST_BYTE = 9'(SECTOR_BYTES - 1);

    // Byte returned for reads of sectors outside the image (blank-disk filler).
    localparam logic [7:0] FILL_BYTE = 8'hE5;

endpackage

// File: rtl/sd_ramdisk.sv
// SD sector-image responder: serves sd_rd/sd_wr requests out of SDRAM, one byte
// at a time through the shared 8-bit SDRAM port.
module sd_ramdisk
    import sd_ramdisk_pkg::*;
#(
    parameter logic [22:0] BASE_ADDR   = 23'h020000,
    parameter logic [31:0] NUM_SECTORS = 32'd400
) (
    input  logic        clk_sys,
    input  logic        reset,

    input  logic [31:0] sd_lba,
    input  logic        sd_rd,
    input  logic        sd_wr,
    output logic        sd_ack,
    output logic [8:0]  sd_buff_addr,
    output logic [7:0]  sd_buff_dout,
    output logic        sd_buff_wr,
    input  logic [7:0]  sd_buff_din,

    output logic [22:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    output logic        mem_rd,
    output logic        mem_we,
    input  logic        mem_ready,

    output logic        busy_err
);

    state_e      state_q,    state_d;
    logic [8:0]  idx_q,      idx_d;        // byte index within the sector
    logic [13:0] lba_q,      lba_d;        // only these LBA bits reach the address
    logic        oor_q,      oor_d;        // accepted LBA is outside the image
    logic        ack_q,      ack_d;
    logic [7:0]  dout_q,     dout_d;
    logic        bwr_q,      bwr_d;
    logic        mem_rd_q,   mem_rd_d;
    logic        mem_we_q,   mem_we_d;
    logic [22:0] mem_addr_q, mem_addr_d;
    logic [7:0]  din_hold_q, din_hold_d;   // requester byte held for the write
    logic        wr_first_q, wr_first_d;   // first cycle of WR_REQ

    logic        req_oor_s;
    logic        last_byte_s;

    assign req_oor_s   = (sd_lba >= NUM_SECTORS);
    assign last_byte_s = (idx_q == LAST_BYTE);

    // State register and all registered outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= 9'd0;
            lba_q      <= 14'd0;
            oor_q      <= 1'b0;
            ack_q      <= 1'b0;
            dout_q     <= 8'd0;
            bwr_q      <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= BASE_ADDR;
            din_hold_q <= 8'd0;
            wr_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            lba_q      <= lba_d;
            oor_q      <= oor_d;
            ack_q      <= ack_d;
            dout_q     <= dout_d;
            bwr_q      <= bwr_d;
            mem_rd_q   <= mem_rd_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            din_hold_q <= din_hold_d;
            wr_first_q <= wr_first_d;
        end
    end

    // Next-state decision for the transfer sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sd_rd) begin
                    state_d = ST_RD_REQ;
                end else if (sd_wr) begin
                    state_d = ST_WR_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                // Out-of-range reads never touch SDRAM and finish in one cycle.
                if (oor_q || mem_ready) begin
                    state_d = ST_RD_STROBE;
                end else begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_STROBE: begin
                if (last_byte_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_WR_ADDR: begin
                state_d = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                if (oor_q || mem_ready) begin
                    if (last_byte_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WR_ADDR;
                    end
                end else begin
                    state_d = ST_WR_REQ;
                end
            end
            ST_DONE: begin
                // Wait for the requester to release so a held level does not retrigger.
                if (!sd_rd && !sd_wr) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and datapath, per state.
    always_comb begin
        idx_d      = idx_q;
        lba_d      = lba_q;
        oor_d      = oor_q;
        ack_d      = ack_q;
        dout_d     = dout_q;
        bwr_d      = 1'b0;
        mem_rd_d   = mem_rd_q;
        mem_we_d   = mem_we_q;
        din_hold_d = din_hold_q;
        wr_first_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sd_rd || sd_wr) begin
                    ack_d    = 1'b1;
                    idx_d    = 9'd0;
                    lba_d    = sd_lba[13:0];
                    oor_d    = req_oor_s;
                    mem_rd_d = sd_rd && !req_oor_s;
                end else begin
                    ack_d = 1'b0;
                end
            end
            ST_RD_REQ: begin
                if (oor_q) begin
                    dout_d = FILL_BYTE;
                    bwr_d  = 1'b1;
                end else if (mem_ready) begin
                    dout_d   = mem_dout;
                    bwr_d    = 1'b1;
                    mem_rd_d = 1'b0;
                end else begin
                    mem_rd_d = 1'b1;
                end
            end
            ST_RD_STROBE: begin
                if (last_byte_s) begin
                    ack_d = 1'b0;
                end else begin
                    idx_d    = idx_q + 9'd1;
                    mem_rd_d = !oor_q;
                end
            end
            ST_WR_ADDR: begin
                mem_we_d   = !oor_q;
                wr_first_d = 1'b1;
            end
            ST_WR_REQ: begin
                // Requester data becomes valid one cycle after the address; grab it then.
                if (wr_first_q) begin
                    din_hold_d = sd_buff_din;
                end else begin
                    din_hold_d = din_hold_q;
                end
                if (oor_q || mem_ready) begin
                    mem_we_d = 1'b0;
                    if (last_byte_s) begin
                        ack_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 9'd1;
                    end
                end else begin
                    mem_we_d = !oor_q;
                end
            end
            ST_DONE: begin
                ack_d = 1'b0;
            end
            default: begin
                ack_d    = 1'b0;
                mem_rd_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
        // Upper LBA bits beyond 14 only matter to the range check.
        mem_addr_d = BASE_ADDR + {lba_d, idx_d};
    end

    assign sd_ack       = ack_q;
    assign sd_buff_addr = idx_q;
    assign sd_buff_dout = dout_q;
    assign sd_buff_wr   = bwr_q;
    assign mem_rd       = mem_rd_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign busy_err     = oor_q;
    // First WR_REQ cycle passes the requester byte straight through, then the held copy.
    assign mem_din      = wr_first_q ? sd_buff_din : din_hold_q;

endmodule

// File: tb/tb_sd_ramdisk.sv
// Randomised bench for sd_ramdisk with an SDRAM model, a requester buffer model
// and a reference disk image kept as a sparse byte map.
module tb_sd_ramdisk;

    localparam logic [22:0] BASE      = 23'h020000;
    localparam logic [31:0] NSECT     = 32'd400;
    localparam logic [7:0]  FILL      = 8'hE5;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [31:0] sd_lba  = 32'd0;
    logic        sd_rd   = 1'b0;
    logic        sd_wr   = 1'b0;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din = 8'd0;
    logic [22:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout  = 8'd0;
    logic        mem_rd;
    logic        mem_we;
    logic        mem_ready = 1'b0;
    logic        busy_err;

    sd_ramdisk #(.BASE_ADDR(BASE), .NUM_SECTORS(NSECT)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_ready(mem_ready),
        .busy_err(busy_err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sparse memories: unwritten bytes read as addr[7:0]^5A.
    logic [7:0] sdram   [int];
    logic [7:0] ref_img [int];
    logic [7:0] wbuf     [512];
    logic [7:0] exp_data [512];

    function automatic logic [7:0] sdram_rd(input int a);
        logic [31:0] av;
        av = a;
        if (sdram.exists(a)) return sdram[a];
        return av[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input int a);
        logic [31:0] av;
        av = a;
        if (ref_img.exists(a)) return ref_img[a];
        return av[7:0] ^ 8'h5A;
    endfunction

    // Byte address of byte i of sector lba, wrapped to the 23-bit SDRAM space.
    function automatic int byte_addr(input logic [31:0] lba, input int i);
        logic [63:0] a;
        a = 64'(BASE) + 64'(lba) * 64'd512 + 64'(i);
        return int'(a & 64'h7F_FFFF);
    endfunction

    // SDRAM model: mem_ready pulses lat+1 cycles after a request is seen.
    int lat = 1;
    int mcnt = 0;
    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mem_ready <= 1'b0;
            mcnt      <= 0;
        end else begin
            mem_ready <= 1'b0;
            if ((mem_rd || mem_we) && !mem_ready) begin
                if (mcnt >= lat) begin
                    mem_ready <= 1'b1;
                    mem_dout  <= sdram_rd(int'(mem_addr));
                    mcnt      <= 0;
                end else begin
                    mcnt <= mcnt + 1;
                end
            end else begin
                mcnt <= 0;
            end
        end
    end

    // Requester buffer: registered read, valid one cycle after the address.
    always @(posedge clk_sys) sd_buff_din <= wbuf[sd_buff_addr];

    // Monitors, sampled on the falling edge.
    int strobes, exp_idx, seq_err, data_err, rd_done, we_done, ack_cycles;
    int bus_err = 0;
    always @(negedge clk_sys) begin
        if (sd_buff_wr) begin
            if (sd_buff_addr != 9'(exp_idx)) seq_err++;
            if (sd_buff_dout !== exp_data[sd_buff_addr]) data_err++;
            exp_idx++;
            strobes++;
        end
        if (mem_rd && mem_ready) rd_done++;
        if (mem_we && mem_ready) begin
            we_done++;
            sdram[int'(mem_addr)] = mem_din;
        end
        if (mem_rd && mem_we) bus_err++;
        if ((mem_rd || mem_we) && !sd_ack) bus_err++;
        if (sd_ack) ack_cycles++;
    end

    // Build expectations for a transfer and clear monitor counters.
    task automatic prep(input bit rd, input bit wr, input logic [31:0] lba, input bit pat_idx);
        bit oor;
        oor = (lba >= NSECT);
        for (int i = 0; i < 512; i++) begin
            exp_data[i] = oor ? FILL : ref_rd(byte_addr(lba, i));
            wbuf[i]     = pat_idx ? 8'(i) : 8'($urandom);
        end
        strobes = 0; exp_idx = 0; seq_err = 0; data_err = 0;
        rd_done = 0; we_done = 0; ack_cycles = 0;
    endtask

    // One complete request/response transfer with all end-of-transfer checks.
    task automatic run_xfer(input bit rd, input bit wr, input logic [31:0] lba,
                            input bit pat_idx, input int hold);
        bit oor, is_wr, timed_out;
        int highs, mism;
        oor   = (lba >= NSECT);
        is_wr = wr && !rd;
        prep(rd, wr, lba, pat_idx);
        @(negedge clk_sys);
        sd_lba = lba; sd_rd = rd; sd_wr = wr;
        @(negedge clk_sys);
        check_eq("ack_rise", 32'(sd_ack), 32'd1);
        check_eq("rd_rise", 32'(mem_rd), 32'(rd && !oor));
        check_eq("we_early", 32'(mem_we), 32'd0);
        if (hold == 0) begin
            sd_rd = 1'b0; sd_wr = 1'b0;
        end
        sd_lba = $urandom;
        timed_out = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk_sys);
            if (!sd_ack) begin
                timed_out = 1'b0;
                break;
            end
        end
        check_eq("ack_fall_timeout", 32'(timed_out), 32'd0);
        check_eq("strobes", 32'(strobes), rd ? 32'd512 : 32'd0);
        check_eq("strobe_seq", 32'(seq_err), 32'd0);
        check_eq("read_data", 32'(data_err), 32'd0);
        check_eq("mem_rd_done", 32'(rd_done), (rd && !oor) ? 32'd512 : 32'd0);
        check_eq("mem_we_done", 32'(we_done), (is_wr && !oor) ? 32'd512 : 32'd0);
        check_eq("busy_err", 32'(busy_err), 32'(oor));
        check_eq("sector_cycles", 32'(ack_cycles), oor ? 32'd1024 : 32'(512 * (lat + 3)));
        check_eq("bus_rules", 32'(bus_err), 32'd0);
        if (is_wr && !oor) begin
            for (int i = 0; i < 512; i++) ref_img[byte_addr(lba, i)] = wbuf[i];
        end
        mism = 0;
        for (int i = 0; i < 512; i++) begin
            if (sdram_rd(byte_addr(lba, i)) !== ref_rd(byte_addr(lba, i))) mism++;
        end
        check_eq("image", 32'(mism), 32'd0);
        if (hold > 0) begin
            highs = 0;
            for (int n = 0; n < hold; n++) begin
                @(negedge clk_sys);
                if (sd_ack) highs++;
            end
            sd_rd = 1'b0;
            for (int n = 0; n < hold; n++) begin
                @(negedge clk_sys);
                if (sd_ack) highs++;
            end
            check_eq("no_retrigger", 32'(highs), 32'd0);
            sd_wr = 1'b0;
        end
        @(negedge clk_sys);
        @(negedge clk_sys);
    endtask

    initial begin
        bit timed_out;
        logic [31:0] lba;
        bit rd, wr;
        for (int i = 0; i < 512; i++) wbuf[i] = 8'd0;
        repeat (3) @(negedge clk_sys);
        check_eq("rst_ack", 32'(sd_ack), 32'd0);
        check_eq("rst_baddr", 32'(sd_buff_addr), 32'd0);
        check_eq("rst_bdout", 32'(sd_buff_dout), 32'd0);
        check_eq("rst_bwr", 32'(sd_buff_wr), 32'd0);
        check_eq("rst_memrd", 32'(mem_rd), 32'd0);
        check_eq("rst_memwe", 32'(mem_we), 32'd0);
        check_eq("rst_maddr", 32'(mem_addr), 32'(BASE));
        check_eq("rst_mdin", 32'(mem_din), 32'd0);
        check_eq("rst_berr", 32'(busy_err), 32'd0);
        reset = 1'b0;
        @(negedge clk_sys);

        lat = 1; run_xfer(1'b1, 1'b0, 32'd3, 1'b0, 0);
        lat = 1; run_xfer(1'b0, 1'b1, 32'd0, 1'b1, 0);
        lat = 2; run_xfer(1'b1, 1'b0, 32'd0, 1'b0, 0);
        lat = 0; run_xfer(1'b1, 1'b0, NSECT, 1'b0, 0);
        lat = 3; run_xfer(1'b1, 1'b0, 32'd5, 1'b0, 0);
        lat = 1; run_xfer(1'b0, 1'b1, 32'h0001_0002, 1'b0, 0);
        lat = 0; run_xfer(1'b1, 1'b0, 32'd2, 1'b0, 0);
        lat = 1; run_xfer(1'b1, 1'b1, 32'd9, 1'b0, 6);

        // Reset in the middle of a read.
        lat = 1;
        prep(1'b1, 1'b0, 32'd7, 1'b0);
        @(negedge clk_sys);
        sd_lba = 32'd7; sd_rd = 1'b1;
        @(negedge clk_sys);
        sd_rd = 1'b0;
        timed_out = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk_sys);
            if (strobes >= 100) begin
                timed_out = 1'b0;
                break;
            end
        end
        check_eq("mid_reset_timeout", 32'(timed_out), 32'd0);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_reset_ack", 32'(sd_ack), 32'd0);
        check_eq("mid_reset_memrd", 32'(mem_rd), 32'd0);
        check_eq("mid_reset_baddr", 32'(sd_buff_addr), 32'd0);
        check_eq("mid_reset_maddr", 32'(mem_addr), 32'(BASE));
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        run_xfer(1'b1, 1'b0, 32'd7, 1'b0, 0);

        lat = 2; run_xfer(1'b1, 1'b0, 32'd11, 1'b0, 12);

        for (int k = 0; k < 6; k++) begin
            case ($urandom_range(0, 3))
                0:       lba = 32'($urandom_range(0, 399));
                1:       lba = 32'd399;
                2:       lba = 32'd400 + 32'($urandom_range(0, 50));
                default: lba = {8'($urandom_range(1, 255)), 24'($urandom_range(0, 399))};
            endcase
            rd  = 1'($urandom_range(0, 1));
            wr  = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
            lat = $urandom_range(0, 3);
            run_xfer(rd, wr, lba, 1'b0, ($urandom_range(0, 1) == 1) ? 4 : 0);
            if (wr && !rd && lba < NSECT) begin
                lat = $urandom_range(0, 3);
                run_xfer(1'b1, 1'b0, lba, 1'b0, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
